// File: rtl/ddn_mcast_router.sv
// ddn_mcast_router: N-in/M-out router with unicast or bitmask multicast, rotating-priority
// atomic arbitration, per-output FWFT FIFOs and a saturating drop counter.
module ddn_mcast_router #(
  parameter int IN_PORTS   = 4,
  parameter int OUT_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_ADDR  = 3,
  parameter int DEST_MODE  = 1,
  parameter int DROP_W     = 16,
  localparam int DW = DEST_MODE ? OUT_PORTS : $clog2(OUT_PORTS),
  localparam int PW = DW + DATA_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [IN_PORTS*PW-1:0]                in_bus_i,
  input  logic [IN_PORTS-1:0]                   in_valid_i,
  output logic [IN_PORTS-1:0]                   in_ready_o,
  output logic [OUT_PORTS*DATA_WIDTH-1:0]       out_bus_o,
  output logic [OUT_PORTS-1:0]                  out_valid_o,
  input  logic [OUT_PORTS-1:0]                  out_ready_i,
  output logic [OUT_PORTS*(FIFO_ADDR+1)-1:0]    out_count_o,
  output logic [DROP_W-1:0]                     drop_count_o
);
  localparam int DEPTH = 1 << FIFO_ADDR;
  localparam int CW    = FIFO_ADDR + 1;
  localparam int PTRW  = $clog2(IN_PORTS);
  localparam int NW    = $clog2(IN_PORTS + 1);

  logic [OUT_PORTS-1:0]  mask [IN_PORTS];
  logic [DATA_WIDTH-1:0] pay  [IN_PORTS];
  logic [DATA_WIDTH-1:0] wdata [OUT_PORTS];
  logic [OUT_PORTS-1:0]  avail, claimed;
  logic [IN_PORTS-1:0]   grant, drop;
  logic [PTRW-1:0]       ptr_q, ptr_d;
  logic [NW-1:0]         ndrop;
  logic [DROP_W:0]       drop_sum;
  logic [DROP_W-1:0]     drop_q;

  for (genvar i = 0; i < IN_PORTS; i++) begin : g_in
    assign pay[i] = in_bus_i[i*PW +: DATA_WIDTH];
    if (DEST_MODE != 0) begin : g_mask
      assign mask[i] = in_bus_i[i*PW+DATA_WIDTH +: OUT_PORTS];
    end else begin : g_idx
      logic [DW-1:0] dest;
      assign dest = in_bus_i[i*PW+DATA_WIDTH +: DW];
      for (genvar j = 0; j < OUT_PORTS; j++) begin : g_oh
        assign mask[i][j] = (32'(dest) == j);
      end
    end
  end

  // A grant needs every requested output free and unclaimed, so multicast is all-or-nothing.
  always_comb begin : arb
    int idx;
    idx = 0;
    claimed = '0;
    grant = '0;
    drop = '0;
    ptr_d = ptr_q;
    for (int k = 0; k < IN_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % IN_PORTS;
      if (in_valid_i[idx] && mask[idx] == '0) drop[idx] = 1'b1;
      else if (in_valid_i[idx] && (mask[idx] & ~avail) == '0 && (mask[idx] & claimed) == '0) begin
        ptr_d = (grant == '0) ? PTRW'((idx + 1) % IN_PORTS) : ptr_d;
        grant[idx] = 1'b1;
        claimed = claimed | mask[idx];
      end
    end
  end

  assign in_ready_o = grant | drop;

  always_comb begin
    for (int j = 0; j < OUT_PORTS; j++) wdata[j] = '0;
    for (int i = 0; i < IN_PORTS; i++)
      for (int j = 0; j < OUT_PORTS; j++)
        wdata[j] = (grant[i] && mask[i][j]) ? pay[i] : wdata[j];
  end

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < IN_PORTS; i++) ndrop = ndrop + NW'(drop[i]);
  end

  assign drop_sum     = {1'b0, drop_q} + (DROP_W+1)'(ndrop);
  assign drop_count_o = drop_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr_q  <= '0;
      drop_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      drop_q <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

  for (genvar j = 0; j < OUT_PORTS; j++) begin : g_out
    logic [CW-1:0]         cnt_q;
    logic [FIFO_ADDR-1:0]  wr_q, rd_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  push, pop;
    assign avail[j] = cnt_q != CW'(DEPTH);
    assign push = claimed[j];
    assign pop  = out_valid_o[j] & out_ready_i[j];
    assign out_valid_o[j] = cnt_q != '0;
    assign out_bus_o[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_q];
    assign out_count_o[j*CW +: CW] = cnt_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt_q <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
        wr_q  <= wr_q + FIFO_ADDR'(push);
        rd_q  <= rd_q + FIFO_ADDR'(pop);
      end
    // Storage needs no reset: entries are only visible through cnt_q/rd_q.
    always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= wdata[j];
  end
endmodule

// File: tb/tb_ddn_mcast_router.sv
// tb_ddn_mcast_router: directed and random checks of the router against a queue-based model;
// a second instance covers index-mode decode and drop-counter saturation.
module tb_ddn_mcast_router;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [143:0] in_bus;
  logic [3:0]   in_valid, in_ready, out_valid, out_ready;
  logic [127:0] out_bus;
  logic [15:0]  out_count, drop_count;

  logic [135:0] in_bus2;
  logic [3:0]   in_valid2, in_ready2;
  logic [95:0]  out_bus2;
  logic [2:0]   out_valid2, out_ready2;
  logic [11:0]  out_count2;
  logic [15:0]  drop_count2;

  int checks = 0, errors = 0;
  logic [31:0] q [4][$];
  int mptr = 0, mdrop = 0;

  ddn_mcast_router dut (
    .clk(clk), .rst_n(rst_n), .in_bus_i(in_bus), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_bus_o(out_bus), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_count_o(out_count), .drop_count_o(drop_count));

  ddn_mcast_router #(.IN_PORTS(4), .OUT_PORTS(3), .DEST_MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_bus_i(in_bus2), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .out_bus_o(out_bus2), .out_valid_o(out_valid2), .out_ready_i(out_ready2),
    .out_count_o(out_count2), .drop_count_o(drop_count2));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int i, input logic [3:0] m, input logic [31:0] d);
    in_valid[i] = 1'b1;
    in_bus[i*36 +: 36] = {m, d};
  endtask

  task automatic off(input int i);
    in_valid[i] = 1'b0;
    in_bus[i*36 +: 36] = 'x;
  endtask

  task automatic send2(input int i, input logic [1:0] dst, input logic [31:0] d);
    in_valid2[i] = 1'b1;
    in_bus2[i*34 +: 34] = {dst, d};
  endtask

  // One clock of the reference model: predict accepts from queue sizes and the priority pointer.
  task automatic cycle();
    logic [3:0] m, claimed, exp_rdy, gr, ev;
    logic [15:0] ec;
    logic [127:0] eb, gb;
    int idx, first, nd;
    bit ok;
    #1;
    claimed = 0; exp_rdy = 0; gr = 0; first = -1; nd = 0;
    for (int k = 0; k < 4; k++) begin
      idx = (mptr + k) % 4;
      m = in_bus[idx*36+32 +: 4];
      if (in_valid[idx]) begin
        if (m == 0) begin
          exp_rdy[idx] = 1'b1;
          nd++;
        end else begin
          ok = (m & claimed) == 0;
          for (int j = 0; j < 4; j++) if (m[j] && q[j].size() >= 8) ok = 0;
          if (ok) begin
            exp_rdy[idx] = 1'b1;
            gr[idx] = 1'b1;
            claimed |= m;
            if (first < 0) first = idx;
          end
        end
      end
    end
    ev = 0; ec = 0; eb = 0; gb = 0;
    for (int j = 0; j < 4; j++) begin
      ev[j] = q[j].size() != 0;
      ec[j*4 +: 4] = 4'(q[j].size());
      if (ev[j]) begin
        eb[j*32 +: 32] = q[j][0];
        gb[j*32 +: 32] = out_bus[j*32 +: 32];
      end
    end
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("out_count", 128'(out_count), 128'(ec));
    chk("out_bus", gb, eb);
    chk("drop_count", 128'(drop_count), 128'(mdrop));
    @(posedge clk);
    for (int j = 0; j < 4; j++) if (out_ready[j] && q[j].size() > 0) void'(q[j].pop_front());
    for (int i = 0; i < 4; i++)
      if (gr[i]) for (int j = 0; j < 4; j++) if (in_bus[i*36+32+j]) q[j].push_back(in_bus[i*36 +: 32]);
    mdrop = (mdrop + nd > 65535) ? 65535 : mdrop + nd;
    if (first >= 0) mptr = (first + 1) % 4;
    #1;
  endtask

  initial begin
    in_valid = 0; in_bus = 'x; out_ready = 0;
    in_valid2 = 0; in_bus2 = 'x; out_ready2 = 3'b111;
    #12;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_count", 128'(out_count), 128'(0));
    chk("rst_drop", 128'(drop_count), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Contention on output 1 from inputs 0 and 2, pointer starting at 0.
    out_ready = 4'hF;
    for (int r = 0; r < 6; r++) begin
      send(0, 4'b0010, 32'hC000_0000 + r);
      send(2, 4'b0010, 32'hC200_0000 + r);
      #1 chk("contention", 128'(in_ready), 128'((r % 2) ? 4'b0100 : 4'b0001));
      cycle();
    end
    off(0); off(2);
    repeat (3) cycle();

    // Unicast with one-cycle latency.
    send(0, 4'b0001, 32'hA5A5_0001);
    #1 chk("uni_ready", 128'(in_ready[0]), 128'(1));
    cycle();
    off(0);
    #1 chk("uni_valid", 128'(out_valid), 128'(4'b0001));
    chk("uni_data", 128'(out_bus[31:0]), 128'(32'hA5A5_0001));
    cycle();

    // Atomic multicast blocked by full output 3.
    out_ready = 4'b0111;
    for (int k = 0; k < 8; k++) begin
      send(3, 4'b1000, 32'h3000 + k);
      cycle();
    end
    off(3);
    send(1, 4'b1011, 32'hB1);
    #1 chk("mc_blocked", 128'(in_ready[1]), 128'(0));
    cycle();
    out_ready = 4'hF;
    #1 chk("mc_popfull", 128'(in_ready[1]), 128'(0));
    cycle();
    out_ready = 4'b0111;
    #1 chk("mc_accept", 128'(in_ready[1]), 128'(1));
    cycle();
    off(1);
    #1 chk("mc_valid", 128'(out_valid), 128'(4'b1011));
    chk("mc_data", 128'(out_bus[63:0]), 128'({32'hB1, 32'hB1}));
    chk("mc_count3", 128'(out_count[15:12]), 128'(8));
    out_ready = 4'hF;
    repeat (10) cycle();

    // Full boundary on output 2 across pointer wrap.
    for (int k = 0; k < 3; k++) begin
      send(3, 4'b0100, 32'h20 + k);
      cycle();
    end
    out_ready = 0;
    for (int k = 0; k < 8; k++) begin
      send(3, 4'b0100, 32'h40 + k);
      cycle();
    end
    send(3, 4'b0100, 32'hFF);
    out_ready = 4'b0100;
    #1 chk("full_refuse", 128'(in_ready[3]), 128'(0));
    cycle();
    out_ready = 0;
    #1 chk("full_cnt7", 128'(out_count[11:8]), 128'(7));
    chk("full_accept", 128'(in_ready[3]), 128'(1));
    cycle();
    off(3);
    #1 chk("full_cnt8", 128'(out_count[11:8]), 128'(8));
    out_ready = 4'hF;
    repeat (10) cycle();

    // Randomised traffic, including drops and back-pressure.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) != 0) send(i, 4'($urandom_range(0, 15)), $urandom);
        else off(i);
      out_ready = 4'($urandom_range(0, 15));
      cycle();
    end

    // Asynchronous reset with data buffered.
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) send(i, 4'(1 << i), 32'h500 + 16 * i + k);
      cycle();
    end
    for (int i = 0; i < 4; i++) off(i);
    #2 rst_n = 1'b0;
    #1 chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_count", 128'(out_count), 128'(0));
    chk("arst_drop", 128'(drop_count), 128'(0));
    for (int j = 0; j < 4; j++) q[j].delete();
    mptr = 0; mdrop = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    send(2, 4'b0001, 32'hD00D);
    cycle();
    off(2);
    #1 chk("arst_first_v", 128'(out_valid), 128'(4'b0001));
    chk("arst_first_d", 128'(out_bus[31:0]), 128'(32'hD00D));
    cycle();

    // Index-mode instance: decode and drops.
    send2(0, 2'd1, 32'h77);
    #1 chk("idx_ready", 128'(in_ready2), 128'(4'b0001));
    @(posedge clk); #1;
    in_valid2 = 0; in_bus2 = 'x;
    #1 chk("idx_valid", 128'(out_valid2), 128'(3'b010));
    chk("idx_data", 128'(out_bus2[63:32]), 128'(32'h77));
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      send2(0, 2'd3, 32'h900 + k);
      #1 chk("drop_ready", 128'(in_ready2), 128'(4'b0001));
      chk("drop_novalid", 128'(out_valid2), 128'(0));
      @(posedge clk); #1;
    end
    in_valid2 = 0;
    #1 chk("drop5", 128'(drop_count2), 128'(5));
    for (int i = 0; i < 4; i++) send2(i, 2'd3, 32'h0);
    repeat (16382) @(posedge clk);
    #1 chk("drop_65533", 128'(drop_count2), 128'(65533));
    @(posedge clk); #1 chk("drop_sat", 128'(drop_count2), 128'(16'hFFFF));
    @(posedge clk); #1 chk("drop_hold", 128'(drop_count2), 128'(16'hFFFF));
    in_valid2 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddn_mcast_router.md
Name: ddn_mcast_router

Overview:
Parametrised N-input, M-output data distribution router for the sparse-matrix operand network. It generalises the single-destination router in several ways:
- routes each packet to one output (index mode) or to any subset of outputs (bitmask multicast mode);
- arbitrates contending inputs with a rotating priority pointer;
- buffers per output in first-word-fall-through FIFOs;
- exposes occupancy and drop counters for the scheduler.

Parameters:
IN_PORTS, 4, number of input ports (2..16)
OUT_PORTS, 4, number of output ports (2..16)
DATA_WIDTH, 32, payload bits per packet
FIFO_ADDR, 3, per-output FIFO depth = 2^FIFO_ADDR
DEST_MODE, 1, 0 = binary index dest (DW = clog2(OUT_PORTS)), 1 = bitmask dest (DW = OUT_PORTS)
DROP_W, 16, width of drop counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_bus  in  IN_PORTS*(DW+DATA_WIDTH)  packed packets; port i at [i*(DW+DATA_WIDTH) +: DW+DATA_WIDTH], dest in upper DW bits, payload in lower DATA_WIDTH bits
in_valid  in  IN_PORTS  per-input packet valid
in_ready  out  IN_PORTS  per-input accept, combinational
out_bus  out  OUT_PORTS*DATA_WIDTH  FIFO head payloads, port j at [j*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  OUT_PORTS  FIFO j non-empty
out_ready  in  OUT_PORTS  consumer pop
out_count  out  OUT_PORTS*(FIFO_ADDR+1)  per-output occupancy
drop_count  out  DROP_W  saturating count of dropped packets

Behaviour:
- Reset (rst_n=0, async): all FIFO pointers and counts = 0, out_valid = 0, out_count = 0, drop_count = 0, priority pointer = 0. out_bus is don't-care while out_valid = 0.
- Destination decode produces mask[i] of OUT_PORTS bits:
  - DEST_MODE=1: mask = dest.
  - DEST_MODE=0: mask = one-hot(dest); mask = 0 when dest >= OUT_PORTS.
- Drop rule: a valid input with mask = 0 is accepted (in_ready=1) the same cycle and discarded. drop_count increments by the number of such inputs that cycle and saturates at all-ones.
- Arbitration (combinational, each cycle):
  - Visit inputs in order ptr, ptr+1, ... mod IN_PORTS.
  - Input i is granted iff in_valid[i], mask[i] != 0, every output in mask[i] has count < DEPTH, and no output in mask[i] was already claimed this cycle by a higher-priority input.
  - A granted input claims all its outputs.
- Multicast is atomic: an input is accepted only when all its outputs are available in the same cycle. There are no partial deliveries.
- in_ready[i] = granted or dropped. in_ready may depend on other inputs' in_valid.
- Transfer: a packet moves when in_valid & in_ready. The payload is written to every claimed FIFO at that edge.
- Pointer update: if any input is granted (drops excluded), ptr <= (first granted index in visit order + 1) mod IN_PORTS. Otherwise ptr holds.
- Output FIFOs are first-word fall-through:
  - out_valid[j] = (count[j] != 0); out_bus slice j = mem[j][rd_ptr[j]].
  - Pop on out_valid[j] & out_ready[j]; out_ready while empty is ignored.
- Latency: a packet accepted at edge t appears with out_valid=1 after edge t, i.e. one cycle.
- Full FIFO: a full FIFO (count = DEPTH) refuses writes even if it pops the same cycle; there is no bypass. On simultaneous push and pop when not full, count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH inclusive (FIFO_ADDR+1 bits). out_count mirrors count.
- Ordering: per output, packets leave in acceptance order. When several inputs are accepted in one cycle, each targets disjoint outputs, so no intra-cycle ordering ambiguity exists.
- Reset mid-operation: all buffered packets are discarded immediately. in_ready may still assert during reset (combinational), but no write occurs while rst_n=0.
- No X propagation: in_bus contents are ignored when in_valid=0.

Test Plan:
- Unicast, DEST_MODE=1: in0 sends mask=0001, data=0xA5A5_0001 on outputs idle, out_ready=1 → in_ready[0]=1 same cycle; out_valid[0]=1 with out_bus[31:0]=0xA5A5_0001 one cycle later; other outputs stay invalid.
- Contention: in0 and in2 both target mask=0010 every cycle, ptr=0 → in0 wins first, ptr becomes 1. Next cycle in2 wins, ptr becomes 3. Grants alternate in0/in2, and output 1 receives an alternating data stream.
- Atomic multicast: in1 sends mask=1011 while output 3 is held full (out_ready[3]=0, 8 entries) → in_ready[1]=0, nothing is written to outputs 0/1. Raise out_ready[3] for one pop, then stop popping → the next cycle in_ready[1]=1 and the payload appears on outputs 0, 1 and 3 simultaneously.
- Full boundary: fill output 2 with 8 packets, then pulse out_ready[2] while in3 pushes to mask=0100 → the push is refused that cycle and count goes 8→7. It is accepted the following cycle, count goes 7→8, and FIFO order is preserved across the pointer wrap.
- Drop: DEST_MODE=0, OUT_PORTS=3, in0 sends dest=3 for 5 cycles → in_ready[0]=1 each cycle, no out_valid, drop_count=5. Force 2^16+2 drops → drop_count saturates at 0xFFFF.
- Async reset: with outputs 0–3 holding 3 entries each, drive rst_n=0 between edges → out_valid=0 and out_count=0 immediately (asynchronous). After rst_n=1, the first accepted packet comes out first on its output.
